// File: rtl/cheshire_prog_addr_decoder.sv
// Runtime-programmable address decoder.
//
// Holds NumRules address rules (start, end, target index, enable) that
// software programs through a 32-bit register-bus config port, and decodes a
// stream of addresses through a one-stage registered pipeline. Each result is
// either the index of the lowest-numbered matching rule or, on a miss, the
// DEFAULT_IDX (when DEFAULT_EN is set) or a decode error. Captured misses are
// counted in a saturating MISS_CNT register for diagnostics. Setting the LOCK
// bit freezes the whole register map until the next reset.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   cfg_*              config port: single-cycle accesses, combinational
//                      rdata/error, writes commit on the clock edge per byte
//   dec_valid_i/_ready_o/_addr_i   address input stream
//   dec_valid_o/_ready_i           result output stream
//   dec_idx_o/_hit_o/_err_o        registered decode result
//
// Register map (byte offsets):
//   0x000 CTRL         bit0 LOCK (set-only), bit1 DEFAULT_EN
//   0x004 DEFAULT_IDX  bits [IdxWidth-1:0]
//   0x008 MISS_CNT     read-only count, an unlocked write clears it
//   0x100 + i*0x20     rule i: +0x00 START_LO, +0x04 START_HI, +0x08 END_LO,
//                      +0x0C END_HI, +0x10 IDX, +0x14 EN (bit0)
module cheshire_prog_addr_decoder #(
    parameter int NumRules   = 6,
    parameter int AddrWidth  = 48,
    parameter int IdxWidth   = 4,
    parameter int DefaultIdx = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // config port
    input  logic                 cfg_req_i,
    input  logic                 cfg_write_i,
    input  logic [11:0]          cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    input  logic [3:0]           cfg_wstrb_i,
    output logic                 cfg_ready_o,
    output logic [31:0]          cfg_rdata_o,
    output logic                 cfg_error_o,
    // decode input stream
    input  logic                 dec_valid_i,
    output logic                 dec_ready_o,
    input  logic [AddrWidth-1:0] dec_addr_i,
    // decode result stream
    output logic                 dec_valid_o,
    input  logic                 dec_ready_i,
    output logic [IdxWidth-1:0]  dec_idx_o,
    output logic                 dec_hit_o,
    output logic                 dec_err_o
);

    localparam int HiWidth = AddrWidth - 32;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic                 lock;
    logic                 default_en;
    logic [IdxWidth-1:0]  default_idx;
    logic [31:0]          miss_cnt;
    logic [AddrWidth-1:0] rule_start [NumRules];
    logic [AddrWidth-1:0] rule_end   [NumRules];
    logic [IdxWidth-1:0]  rule_idx   [NumRules];
    logic                 rule_en    [NumRules];

    // Byte-wise merge of write data into an existing 32-bit register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // Upper address word: only HiWidth bits exist, the rest drop on write.
    function automatic logic [HiWidth-1:0] merge_hi(input logic [HiWidth-1:0] old_val,
                                                    input logic [31:0]        wdata,
                                                    input logic [3:0]         wstrb);
        logic [31:0] res;
        res = merge_bytes(32'(old_val), wdata, wstrb);
        return res[HiWidth-1:0];
    endfunction

    function automatic logic [IdxWidth-1:0] merge_idx(input logic [IdxWidth-1:0] old_val,
                                                      input logic [31:0]         wdata,
                                                      input logic [3:0]          wstrb);
        logic [31:0] res;
        res = merge_bytes(32'(old_val), wdata, wstrb);
        return res[IdxWidth-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Config address decode
    // ------------------------------------------------------------------
    logic       aligned;
    logic       is_ctrl;
    logic       is_didx;
    logic       is_miss;
    logic       rule_ok;
    logic [6:0] rule_sel;
    logic [2:0] reg_off;
    logic       mapped;
    logic       cfg_we;
    logic [31:0] rdata_c;

    assign aligned  = (cfg_addr_i[1:0] == 2'b00);
    assign is_ctrl  = aligned && (cfg_addr_i[11:2] == 10'd0);
    assign is_didx  = aligned && (cfg_addr_i[11:2] == 10'd1);
    assign is_miss  = aligned && (cfg_addr_i[11:2] == 10'd2);
    // Rule windows are 0x20 bytes starting at 0x100; only the first six
    // words of each window are populated.
    assign rule_sel = cfg_addr_i[11:5] - 7'd8;
    assign reg_off  = cfg_addr_i[4:2];
    assign rule_ok  = aligned && (cfg_addr_i[11:8] != 4'd0) &&
                      (rule_sel < 7'(NumRules)) && (reg_off <= 3'd5);
    assign mapped   = is_ctrl || is_didx || is_miss || rule_ok;

    assign cfg_ready_o = 1'b1;
    assign cfg_error_o = cfg_req_i && (!mapped || (cfg_write_i && lock));
    assign cfg_we      = cfg_req_i && cfg_write_i && !cfg_error_o;

    always_comb begin
        rdata_c = '0;
        if (is_ctrl) begin
            rdata_c = {30'd0, default_en, lock};
        end else if (is_didx) begin
            rdata_c = 32'(default_idx);
        end else if (is_miss) begin
            rdata_c = miss_cnt;
        end else if (rule_ok) begin
            for (int i = 0; i < NumRules; i++) begin
                if (rule_sel == 7'(i)) begin
                    case (reg_off)
                        3'd0:    rdata_c = rule_start[i][31:0];
                        3'd1:    rdata_c = 32'(rule_start[i][AddrWidth-1:32]);
                        3'd2:    rdata_c = rule_end[i][31:0];
                        3'd3:    rdata_c = 32'(rule_end[i][AddrWidth-1:32]);
                        3'd4:    rdata_c = 32'(rule_idx[i]);
                        3'd5:    rdata_c = {31'd0, rule_en[i]};
                        default: rdata_c = '0;
                    endcase
                end
            end
        end
    end

    assign cfg_rdata_o = (cfg_req_i && !cfg_write_i && !cfg_error_o) ? rdata_c : 32'd0;

    // ------------------------------------------------------------------
    // Config register writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock        <= 1'b0;
            default_en  <= 1'b0;
            default_idx <= IdxWidth'(DefaultIdx);
            for (int i = 0; i < NumRules; i++) begin
                rule_start[i] <= '0;
                rule_end[i]   <= '0;
                rule_idx[i]   <= '0;
                rule_en[i]    <= 1'b0;
            end
        end else if (cfg_we) begin
            if (is_ctrl && cfg_wstrb_i[0]) begin
                // LOCK is sticky: a write can set it but never clear it.
                lock       <= lock | cfg_wdata_i[0];
                default_en <= cfg_wdata_i[1];
            end
            if (is_didx) begin
                default_idx <= merge_idx(default_idx, cfg_wdata_i, cfg_wstrb_i);
            end
            for (int i = 0; i < NumRules; i++) begin
                if (rule_ok && (rule_sel == 7'(i))) begin
                    case (reg_off)
                        3'd0: rule_start[i][31:0] <= merge_bytes(rule_start[i][31:0],
                                                                 cfg_wdata_i, cfg_wstrb_i);
                        3'd1: rule_start[i][AddrWidth-1:32] <= merge_hi(rule_start[i][AddrWidth-1:32],
                                                                        cfg_wdata_i, cfg_wstrb_i);
                        3'd2: rule_end[i][31:0] <= merge_bytes(rule_end[i][31:0],
                                                               cfg_wdata_i, cfg_wstrb_i);
                        3'd3: rule_end[i][AddrWidth-1:32] <= merge_hi(rule_end[i][AddrWidth-1:32],
                                                                      cfg_wdata_i, cfg_wstrb_i);
                        3'd4: rule_idx[i] <= merge_idx(rule_idx[i], cfg_wdata_i, cfg_wstrb_i);
                        3'd5: if (cfg_wstrb_i[0]) rule_en[i] <= cfg_wdata_i[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Address match (uses register state from before the edge)
    // ------------------------------------------------------------------
    logic                hit_c;
    logic                err_c;
    logic [IdxWidth-1:0] idx_c;

    always_comb begin
        hit_c = 1'b0;
        err_c = 1'b0;
        idx_c = '0;
        // Ascending scan with a found flag gives lowest-numbered-rule priority.
        // start >= end can never satisfy both bounds, so such rules never hit.
        for (int i = 0; i < NumRules; i++) begin
            if (!hit_c && rule_en[i] &&
                (dec_addr_i >= rule_start[i]) && (dec_addr_i < rule_end[i])) begin
                hit_c = 1'b1;
                idx_c = rule_idx[i];
            end
        end
        if (!hit_c) begin
            if (default_en) begin
                idx_c = default_idx;
            end else begin
                err_c = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline stage
    // Handshake: a beat transfers on a cycle where valid && ready are both
    // high at the clock edge. Once dec_valid_o is raised it stays high and
    // the result fields stay stable until dec_ready_i accepts it. The input
    // side is ready whenever the output register is empty or being drained.
    // ------------------------------------------------------------------
    logic capture;

    assign dec_ready_o = !dec_valid_o || dec_ready_i;
    assign capture     = dec_valid_i && dec_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_valid_o <= 1'b0;
            dec_idx_o   <= '0;
            dec_hit_o   <= 1'b0;
            dec_err_o   <= 1'b0;
        end else if (capture) begin
            dec_valid_o <= 1'b1;
            dec_idx_o   <= idx_c;
            dec_hit_o   <= hit_c;
            dec_err_o   <= err_c;
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Miss counter: saturating, a clear in the same cycle wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_cnt <= '0;
        end else if (cfg_we && is_miss) begin
            miss_cnt <= '0;
        end else if (capture && !hit_c && (miss_cnt != 32'hFFFF_FFFF)) begin
            miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule
